luhn_digit_engine: RTL and testbench

- Sits directly downstream of the PS/2 scancode converter.
- Consumes its one-hot digit bus and its three active-low controls: shift, check_luhn and out_reset.
- Collects up to MAX_DIGITS decimal digits in a shift buffer.
- When a check is requested, a sequential FSM runs the Luhn checksum over the stored digits, one digit per cycle, and reports pass/fail for the display and LED logic.

---
 rtl/luhn_digit_engine.sv | 156 +++++++++++++++
 tb/tb_luhn_digit_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/luhn_digit_engine.sv
// Digit buffer fed by the PS/2 scancode converter, plus a one-digit-per-cycle Luhn checker.
// Slot 0 holds the newest digit, so it is the check digit (undoubled) when the sum runs.
module luhn_digit_engine #(
  parameter int unsigned MAX_DIGITS = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [9:0]              number,
  input  logic                    shift_n,
  input  logic                    check_n,
  input  logic                    clear_n,
  output logic [4*MAX_DIGITS-1:0] digits,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    busy,
  output logic                    result_valid,
  output logic                    luhn_pass
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    shift_q, shift_d;
  logic                    check_q, check_d;
  logic [4*MAX_DIGITS-1:0] digits_q, digits_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [3:0]              sum_q, sum_d;
  logic                    valid_q, valid_d;
  logic                    pass_q, pass_d;

  logic       push_req, chk_req;
  logic [3:0] num_bcd;
  logic [3:0] num_bits;
  logic       num_ok;
  logic       full;
  logic [3:0] cur_d;
  logic [4:0] dbl;
  logic [3:0] term;
  logic [4:0] sum_ext;
  logic [3:0] sum_nxt;

  assign push_req = shift_q & ~shift_n;
  assign chk_req  = check_q & ~check_n;
  assign full     = (count_q == CNT_W'(MAX_DIGITS));

  // One-hot to BCD; the bit count rejects zero-hot and multi-hot codes.
  always_comb begin
    num_bcd  = '0;
    num_bits = '0;
    for (int k = 0; k < 10; k++) begin
      if (number[k]) begin
        num_bcd  = 4'(k);
        num_bits = num_bits + 4'd1;
      end
    end
  end
  assign num_ok = (num_bits == 4'd1);

  always_comb begin
    cur_d = '0;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (idx_q == CNT_W'(i)) cur_d = digits_q[4*i +: 4];
    end
  end

  // Odd positions are doubled and folded back to a single digit.
  always_comb begin
    dbl = {cur_d, 1'b0};
    if (!idx_q[0]) term = cur_d;
    else if (dbl > 5'd9) term = 4'(dbl - 5'd9);
    else term = dbl[3:0];
    sum_ext = {1'b0, sum_q} + {1'b0, term};
    sum_nxt = (sum_ext >= 5'd10) ? 4'(sum_ext - 5'd10) : sum_ext[3:0];
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_n;
    check_d  = check_n;
    digits_d = digits_q;
    count_d  = count_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    valid_d  = valid_q;
    pass_d   = pass_q;
    if (!clear_n) begin
      state_d  = StIdle;
      digits_d = '0;
      count_d  = '0;
      idx_d    = '0;
      sum_d    = '0;
      valid_d  = 1'b0;
      pass_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (chk_req) begin
            idx_d   = '0;
            sum_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            state_d = (count_q >= CNT_W'(2)) ? StCalc : StDone;
          end else if (push_req && num_ok && !full) begin
            digits_d = {digits_q[4*MAX_DIGITS-5:0], num_bcd};
            count_d  = count_q + CNT_W'(1);
            valid_d  = 1'b0;
            pass_d   = 1'b0;
          end
        end
        StCalc: begin
          sum_d = sum_nxt;
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == count_q - CNT_W'(1)) state_d = StDone;
        end
        StDone: begin
          pass_d  = (sum_q == 4'd0) && (count_q >= CNT_W'(2));
          valid_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= 1'b1;
      check_q  <= 1'b1;
      digits_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      check_q  <= check_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
    end
  end

  assign digits       = digits_q;
  assign digit_count  = count_q;
  assign busy         = (state_q != StIdle);
  assign result_valid = valid_q;
  assign luhn_pass    = pass_q;

endmodule

// File: tb/tb_luhn_digit_engine.sv
// Scoreboard bench for luhn_digit_engine: a queue model of the digit buffer predicts
// contents, and expected pass/latency entries are queued at each check start.
module tb_luhn_digit_engine;

  localparam int MaxDigits = 16;
  localparam int CntW      = 5;

  logic                   CLOCK_50 = 1'b0;
  logic                   reset;
  logic [9:0]             number;
  logic                   shift_n;
  logic                   check_n;
  logic                   clear_n;
  logic [4*MaxDigits-1:0] digits;
  logic [CntW-1:0]        digit_count;
  logic                   busy;
  logic                   result_valid;
  logic                   luhn_pass;

  luhn_digit_engine #(
    .MAX_DIGITS(MaxDigits),
    .CNT_W     (CntW)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .number      (number),
    .shift_n     (shift_n),
    .check_n     (check_n),
    .clear_n     (clear_n),
    .digits      (digits),
    .digit_count (digit_count),
    .busy        (busy),
    .result_valid(result_valid),
    .luhn_pass   (luhn_pass)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic pass;
    int   lat;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];  // model buffer, index 0 = newest digit
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < mq.size(); i++) v[4*i +: 4] = 4'(mq[i]);
    return v;
  endfunction

  function automatic logic model_luhn();
    int s = 0;
    for (int i = 0; i < mq.size(); i++) begin
      int t = mq[i];
      if (i % 2 == 1) begin
        t = t * 2;
        if (t > 9) t = t - 9;
      end
      s += t;
    end
    return (mq.size() >= 2) && (s % 10 == 0);
  endfunction

  task automatic push_digit(input int d);
    number  = 10'b1 << d;
    shift_n = 1'b0;
    tick();
    shift_n = 1'b1;
    tick();
    if (mq.size() < MaxDigits) mq.push_front(d);
  endtask

  task automatic do_clear();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    mq.delete();
  endtask

  task automatic push_list(input int ds[$]);
    foreach (ds[i]) push_digit(ds[i]);
  endtask

  // Starts a check; optionally pushes mid-CALC or aborts with clear at E+5.
  task automatic run_check(input string tag, input bit inject, input bit abort);
    int   n   = mq.size();
    int   lat = (n >= 2) ? n + 2 : 2;
    bit   got = 1'b0;
    exp_t e;
    check_n = 1'b0;
    tick();
    check_n = 1'b1;
    if (!abort) exp_q.push_back('{model_luhn(), lat});
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k == 1) check_value({tag, " busy@E+1"}, 64'(busy), 64'd1);
      if (inject && k == 3) begin
        number  = 10'b1 << 5;
        shift_n = 1'b0;
      end
      if (inject && k == 4) shift_n = 1'b1;
      if (inject && k == 6) begin
        check_value({tag, " count during calc"}, 64'(digit_count), 64'(mq.size()));
        check_value({tag, " digits during calc"}, digits, model_vec());
      end
      if (abort && k == 5) begin
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        mq.delete();
        check_value({tag, " busy after clear"}, 64'(busy), 64'd0);
        check_value({tag, " count after clear"}, 64'(digit_count), 64'd0);
        check_value({tag, " valid after clear"}, 64'(result_valid), 64'd0);
        got = 1'b1;
      end else if (result_valid) begin
        got = 1'b1;
        e   = exp_q.pop_front();
        check_value({tag, " pass"}, 64'(luhn_pass), 64'(e.pass));
        check_value({tag, " latency"}, 64'(k), 64'(e.lat));
        check_value({tag, " busy at result"}, 64'(busy), 64'd0);
      end else begin
        tick();
      end
    end
    if (!got) begin
      check_value({tag, " timeout"}, 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq_a[$] = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
    int seq_b[$] = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 4};
    int seq_c[$] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6};
    bit seen;

    reset   = 1'b1;
    number  = '0;
    shift_n = 1'b1;
    check_n = 1'b1;
    clear_n = 1'b1;
    tick();
    tick();
    check_value("reset digits", digits, 64'd0);
    check_value("reset count", 64'(digit_count), 64'd0);
    check_value("reset busy", 64'(busy), 64'd0);
    check_value("reset valid", 64'(result_valid), 64'd0);
    check_value("reset pass", 64'(luhn_pass), 64'd0);
    reset = 1'b0;
    tick();

    // Classic valid number
    push_list(seq_a);
    check_value("A count", 64'(digit_count), 64'd11);
    check_value("A slot0", 64'(digits[3:0]), 64'd3);
    check_value("A slot10", 64'(digits[43:40]), 64'd7);
    check_value("A digits", digits, model_vec());
    run_check("A", 1'b0, 1'b0);
    repeat (3) tick();
    check_value("A valid held", 64'(result_valid), 64'd1);
    push_digit(5);
    check_value("A valid cleared by push", 64'(result_valid), 64'd0);
    check_value("A count after push", 64'(digit_count), 64'd12);
    do_clear();
    check_value("clear count", 64'(digit_count), 64'd0);
    check_value("clear digits", digits, 64'd0);

    // Bad check digit
    push_list(seq_b);
    check_value("B digits", digits, model_vec());
    run_check("B", 1'b0, 1'b0);
    do_clear();

    // Full buffer drops the 17th push
    push_list(seq_c);
    check_value("C count full", 64'(digit_count), 64'd16);
    push_digit(5);
    check_value("C count after overflow", 64'(digit_count), 64'd16);
    check_value("C digits after overflow", digits, model_vec());
    run_check("C", 1'b0, 1'b0);
    do_clear();

    // Held-low shift pushes once; non-one-hot number dropped
    number  = 10'b1 << 4;
    shift_n = 1'b0;
    repeat (20) tick();
    shift_n = 1'b1;
    tick();
    mq.push_front(4);
    check_value("hold count", 64'(digit_count), 64'd1);
    check_value("hold digits", digits, model_vec());
    number  = 10'b0000000110;
    shift_n = 1'b0;
    tick();
    shift_n = 1'b1;
    tick();
    check_value("multihot count", 64'(digit_count), 64'd1);
    number  = 10'b0;
    shift_n = 1'b0;
    tick();
    shift_n = 1'b1;
    tick();
    check_value("zerohot count", 64'(digit_count), 64'd1);
    run_check("count1", 1'b0, 1'b0);
    do_clear();
    run_check("count0", 1'b0, 1'b0);

    // Clear aborts a running check; no result may appear afterwards
    push_list(seq_a);
    run_check("abort", 1'b0, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    check_value("abort no late result", 64'(seen), 64'd0);

    // Push during CALC is ignored
    push_list(seq_a);
    run_check("inject", 1'b1, 1'b0);
    check_value("inject count after", 64'(digit_count), 64'd11);
    check_value("inject digits after", digits, model_vec());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
